// File: rtl/apb_pkg.sv
// APB request/response bundles exchanged between the bridge and the slave.
package apb_pkg;

    localparam int APB_W = 16;

    // Signals driven by the bridge toward the APB slave.
    typedef struct packed {
        logic             psel;
        logic             penable;
        logic             pwrite;
        logic [APB_W-1:0] paddr;
        logic [APB_W-1:0] pwdata;
    } apb_req_s;

    // Signals returned by the APB slave.
    typedef struct packed {
        logic             pready;
        logic             pslverr;
        logic [APB_W-1:0] prdata;
    } apb_resp_s;

endpackage

// File: rtl/fsm_pkg.sv
// Bridge control states.
package fsm_pkg;

    // IDLE waits for a head flit, RECV collects the rest of the request,
    // APB_SETUP/APB_ACCESS run the bus transfer, RESP streams the reply.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RECV       = 3'd1,
        APB_SETUP  = 3'd2,
        APB_ACCESS = 3'd3,
        RESP       = 3'd4
    } state_e;

endpackage

// File: rtl/ni_pkg.sv
// Network-interface packet definitions shared by the NoC-to-APB bridge.
package ni_pkg;

    localparam int FLIT_W      = 16;
    localparam int TOTAL_FLITS = 4;
    localparam int CNT_W       = $clog2(TOTAL_FLITS);

    localparam logic [CNT_W-1:0] FIRST_FLIT = CNT_W'(0);
    localparam logic [CNT_W-1:0] BODY0_FLIT = CNT_W'(1);
    localparam logic [CNT_W-1:0] BODY1_FLIT = CNT_W'(2);
    localparam logic [CNT_W-1:0] LAST_FLIT  = CNT_W'(TOTAL_FLITS - 1);

    // Request packet as it arrives from the NoC, head first.
    typedef struct packed {
        logic [FLIT_W-1:0]      head_flit;
        logic [1:0][FLIT_W-1:0] body_flit;
        logic [FLIT_W-1:0]      tail_flit;
    } req_packet_s;

    // Response packet sent back to the requester, head first.
    typedef struct packed {
        logic [FLIT_W-1:0]      head_flit;
        logic [1:0][FLIT_W-1:0] body_flit;
        logic [FLIT_W-1:0]      tail_flit;
    } resp_packet_s;

    // Response head swaps source and destination so the packet routes back
    // to the requester, and reports the slave error flag in bit 6.
    function automatic logic [FLIT_W-1:0] buildRespHead(
        input logic [FLIT_W-1:0] reqHead,
        input logic              slvErr
    );
        buildRespHead = {reqHead[11:8], reqHead[15:12], reqHead[7], slvErr, 6'b000000};
    endfunction

    // Selects which flit of a response packet goes out for a given index.
    function automatic logic [FLIT_W-1:0] pickFlit(
        input resp_packet_s       pkt,
        input logic [CNT_W-1:0]   idx
    );
        case (idx)
            FIRST_FLIT: pickFlit = pkt.head_flit;
            BODY0_FLIT: pickFlit = pkt.body_flit[0];
            BODY1_FLIT: pickFlit = pkt.body_flit[1];
            default:    pickFlit = pkt.tail_flit;
        endcase
    endfunction

endpackage

// File: rtl/apb_master.sv
// APB master: holds address/data/direction for the current transfer,
// drives psel/penable for the setup and access phases, and captures the
// slave's read data and error flag when the transfer completes.
module apb_master
    import apb_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [APB_W-1:0] i_addr,
    input  logic [APB_W-1:0] i_wdata,
    input  logic             i_write,
    input  logic             i_setup,
    input  logic             i_access,
    input  apb_resp_s        i_resp,
    output apb_req_s         o_req,
    output logic             o_done,
    output logic [APB_W-1:0] o_prdata,
    output logic             o_pslverr
);

    logic [APB_W-1:0] r_paddr;
    logic [APB_W-1:0] r_pwdata;
    logic             r_pwrite;
    logic [APB_W-1:0] r_prdata;
    logic             r_pslverr;
    logic             w_done;

    // The transfer ends on the first access-phase edge where the slave is ready;
    // any number of wait states simply keeps the access phase going.
    assign w_done = i_access && i_resp.pready;

    // Address, data and direction are loaded once per transfer so they stay
    // stable through both phases and keep their value between transfers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
        end else if (i_load) begin
            r_paddr  <= i_addr;
            r_pwdata <= i_wdata;
            r_pwrite <= i_write;
        end
    end

    // Completion snapshot of the slave response, used to build the reply packet.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else if (w_done) begin
            r_prdata  <= i_resp.prdata;
            r_pslverr <= i_resp.pslverr;
        end
    end

    // Bus control follows the phase flags directly so a reset drops psel at once.
    always_comb begin
        o_req         = '0;
        o_req.psel    = i_setup || i_access;
        o_req.penable = i_access;
        o_req.pwrite  = r_pwrite;
        o_req.paddr   = r_paddr;
        o_req.pwdata  = r_pwdata;
    end

    assign o_done    = w_done;
    assign o_prdata  = r_prdata;
    assign o_pslverr = r_pslverr;

endmodule

// File: rtl/top.sv
// NoC-to-APB bridge: receives a four-flit request packet, performs one APB
// transfer through apb_master, and returns a four-flit response packet.
module top
    import ni_pkg::*;
    import apb_pkg::*;
    import fsm_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [FLIT_W-1:0] i_flit,
    input  logic              enable,
    output logic [FLIT_W-1:0] o_flit,
    output logic              ready,
    output logic              valid_out,
    output apb_req_s          apb_req_signals,
    input  apb_resp_s         apb_resp_signals
);

    state_e            r_state;
    state_e            w_nextState;
    logic [CNT_W-1:0]  r_flitCnt;
    req_packet_s       r_req;
    logic              r_outOfReset;

    logic              w_rxPhase;
    logic              w_accept;
    logic              w_tailAccept;
    logic              w_apbDone;
    logic [APB_W-1:0]  w_prdata;
    logic              w_pslverr;
    resp_packet_s      w_resp;

    // Input is only taken while collecting a packet, and never in the very
    // first cycle after reset is released.
    assign w_rxPhase    = (r_state == IDLE) || (r_state == RECV);
    assign ready        = r_outOfReset && w_rxPhase;
    assign w_accept     = enable && ready;
    assign w_tailAccept = w_accept && (r_state == RECV) && (r_flitCnt == LAST_FLIT);

    // Marks the first clock edge after reset so ready is held low during
    // reset and rises on the following cycle.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_outOfReset <= 1'b0;
        end else begin
            r_outOfReset <= 1'b1;
        end
    end

    // Bridge state register.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The flit counter indexes incoming flits while receiving and outgoing
    // flits while responding; it wraps to zero after the tail in both cases,
    // so it is already zero whenever a packet starts.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_flitCnt <= '0;
            r_req     <= '0;
        end else if (w_accept) begin
            case (r_flitCnt)
                FIRST_FLIT: r_req.head_flit    <= i_flit;
                BODY0_FLIT: r_req.body_flit[0] <= i_flit;
                BODY1_FLIT: r_req.body_flit[1] <= i_flit;
                default:    r_req.tail_flit    <= i_flit;
            endcase
            r_flitCnt <= r_flitCnt + CNT_W'(1);
        end else if (r_state == RESP) begin
            r_flitCnt <= r_flitCnt + CNT_W'(1);
        end
    end

    // Next-state logic plus the response-side outputs, which are quiet
    // outside the response phase.
    always_comb begin
        w_nextState = r_state;
        valid_out   = 1'b0;
        o_flit      = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = RECV;
                end
            end
            RECV: begin
                if (w_tailAccept) begin
                    w_nextState = APB_SETUP;
                end
            end
            APB_SETUP: begin
                w_nextState = APB_ACCESS;
            end
            APB_ACCESS: begin
                if (w_apbDone) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                valid_out = 1'b1;
                o_flit    = pickFlit(w_resp, r_flitCnt);
                if (r_flitCnt == LAST_FLIT) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Response packet assembled from the captured request and APB result;
    // writes return zero data whatever the slave put on prdata.
    always_comb begin
        w_resp              = '0;
        w_resp.head_flit    = buildRespHead(r_req.head_flit, w_pslverr);
        w_resp.body_flit[0] = r_req.body_flit[0];
        w_resp.body_flit[1] = r_req.head_flit[7] ? '0 : w_prdata;
        w_resp.tail_flit    = r_req.tail_flit;
    end

    apb_master u_apb_master (
        .i_clk     (clk),
        .i_rst     (resetn),
        .i_load    (w_tailAccept),
        .i_addr    (r_req.body_flit[0]),
        .i_wdata   (r_req.body_flit[1]),
        .i_write   (r_req.head_flit[7]),
        .i_setup   (r_state == APB_SETUP),
        .i_access  (r_state == APB_ACCESS),
        .i_resp    (apb_resp_signals),
        .o_req     (apb_req_signals),
        .o_done    (w_apbDone),
        .o_prdata  (w_prdata),
        .o_pslverr (w_pslverr)
    );

endmodule

// File: tb/tb_top.sv
// Directed testbench for the NoC-to-APB bridge.
module tb_top;
    import ni_pkg::*;
    import apb_pkg::*;

    logic              clk;
    logic              resetn;
    logic [FLIT_W-1:0] iFlit;
    logic              enable;
    logic [FLIT_W-1:0] oFlit;
    logic              ready;
    logic              validOut;
    apb_req_s          apbReq;
    apb_resp_s         apbResp;

    int errors = 0;
    int checks = 0;

    top dut (
        .clk              (clk),
        .resetn           (resetn),
        .i_flit           (iFlit),
        .enable           (enable),
        .o_flit           (oFlit),
        .ready            (ready),
        .valid_out        (validOut),
        .apb_req_signals  (apbReq),
        .apb_resp_signals (apbResp)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares a 16-bit observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
        end
    endtask

    // Compares a single-bit observed value with its expectation.
    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Presents one flit for a single accepting edge.
    task automatic applyStimulus(input logic [15:0] flit);
        enable = 1'b1;
        iFlit  = flit;
        step();
        enable = 1'b0;
        iFlit  = '0;
    endtask

    // Sends a whole request back to back; returns in the APB setup cycle.
    task automatic sendPacket(input logic [15:0] h, input logic [15:0] a, input logic [15:0] d, input logic [15:0] t);
        applyStimulus(h);
        applyStimulus(a);
        applyStimulus(d);
        applyStimulus(t);
    endtask

    // Checks the four response flits and the return to idle afterwards.
    task automatic checkResponse(input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2, input logic [15:0] r3);
        logic [3:0][15:0] exp;
        exp = {r3, r2, r1, r0};
        for (int i = 0; i < 4; i++) begin
            checkBit($sformatf("valid_out flit%0d", i), validOut, 1'b1);
            checkBit($sformatf("ready in resp flit%0d", i), ready, 1'b0);
            checkOutput($sformatf("o_flit flit%0d", i), oFlit, exp[i]);
            step();
        end
        checkBit("valid_out after resp", validOut, 1'b0);
        checkOutput("o_flit after resp", oFlit, 16'h0000);
        checkBit("ready after resp", ready, 1'b1);
        checkBit("psel after resp", apbReq.psel, 1'b0);
        checkBit("penable after resp", apbReq.penable, 1'b0);
    endtask

    // Guard against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        clk     = 1'b0;
        resetn  = 1'b1;
        enable  = 1'b0;
        iFlit   = '0;
        apbResp = '0;

        // Reset values
        #1;
        checkBit("reset ready", ready, 1'b0);
        checkBit("reset valid_out", validOut, 1'b0);
        checkOutput("reset o_flit", oFlit, 16'h0000);
        checkBit("reset psel", apbReq.psel, 1'b0);
        checkBit("reset penable", apbReq.penable, 1'b0);
        checkBit("reset pwrite", apbReq.pwrite, 1'b0);
        checkOutput("reset paddr", apbReq.paddr, 16'h0000);
        checkOutput("reset pwdata", apbReq.pwdata, 16'h0000);
        step();
        step();
        resetn = 1'b0;
        step();
        checkBit("ready after release", ready, 1'b1);
        checkBit("valid_out after release", validOut, 1'b0);

        // Write, zero wait states; prdata is noise that must not leak into the reply
        apbResp.pready  = 1'b1;
        apbResp.pslverr = 1'b0;
        apbResp.prdata  = 16'hFFFF;
        sendPacket(16'h2180, 16'h0010, 16'hBEEF, 16'h0005);
        checkBit("wr setup ready", ready, 1'b0);
        checkBit("wr setup psel", apbReq.psel, 1'b1);
        checkBit("wr setup penable", apbReq.penable, 1'b0);
        checkBit("wr setup pwrite", apbReq.pwrite, 1'b1);
        checkOutput("wr setup paddr", apbReq.paddr, 16'h0010);
        checkOutput("wr setup pwdata", apbReq.pwdata, 16'hBEEF);
        checkBit("wr setup valid_out", validOut, 1'b0);
        step();
        checkBit("wr access psel", apbReq.psel, 1'b1);
        checkBit("wr access penable", apbReq.penable, 1'b1);
        checkOutput("wr access paddr", apbReq.paddr, 16'h0010);
        checkBit("wr access valid_out", validOut, 1'b0);
        step();
        checkResponse(16'h1280, 16'h0010, 16'h0000, 16'h0005);
        checkOutput("wr paddr held", apbReq.paddr, 16'h0010);
        checkBit("wr pwrite held", apbReq.pwrite, 1'b1);

        // Read, zero wait states
        apbResp.prdata = 16'h1234;
        sendPacket(16'h2100, 16'h0020, 16'h0000, 16'h0007);
        checkBit("rd setup psel", apbReq.psel, 1'b1);
        checkBit("rd setup pwrite", apbReq.pwrite, 1'b0);
        checkOutput("rd setup paddr", apbReq.paddr, 16'h0020);
        step();
        checkBit("rd access penable", apbReq.penable, 1'b1);
        step();
        checkResponse(16'h1200, 16'h0020, 16'h1234, 16'h0007);

        // Read with pready low for three access cycles
        apbResp.pready = 1'b0;
        apbResp.prdata = 16'h5A5A;
        sendPacket(16'h2100, 16'h0030, 16'h0000, 16'h0009);
        checkBit("ws setup penable", apbReq.penable, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkBit($sformatf("ws access%0d psel", i), apbReq.psel, 1'b1);
            checkBit($sformatf("ws access%0d penable", i), apbReq.penable, 1'b1);
            checkBit($sformatf("ws access%0d valid_out", i), validOut, 1'b0);
            if (i == 3) apbResp.pready = 1'b1;
        end
        step();
        checkResponse(16'h1200, 16'h0030, 16'h5A5A, 16'h0009);

        // Write answered with a slave error
        apbResp.pslverr = 1'b1;
        apbResp.prdata  = 16'hFFFF;
        sendPacket(16'h2180, 16'h0040, 16'h1111, 16'h000A);
        step();
        step();
        checkResponse(16'h12C0, 16'h0040, 16'h0000, 16'h000A);
        apbResp.pslverr = 1'b0;

        // Two-cycle gap in enable between the body flits
        applyStimulus(16'h3480);
        applyStimulus(16'h0050);
        step();
        checkBit("gap ready", ready, 1'b1);
        checkBit("gap psel", apbReq.psel, 1'b0);
        step();
        checkBit("gap valid_out", validOut, 1'b0);
        applyStimulus(16'hCAFE);
        applyStimulus(16'h000B);
        checkBit("gap setup psel", apbReq.psel, 1'b1);
        checkOutput("gap setup paddr", apbReq.paddr, 16'h0050);
        checkOutput("gap setup pwdata", apbReq.pwdata, 16'hCAFE);
        checkBit("gap setup pwrite", apbReq.pwrite, 1'b1);
        step();
        step();
        checkResponse(16'h4380, 16'h0050, 16'h0000, 16'h000B);

        // Reset pulse in the middle of an access phase
        apbResp.pready = 1'b0;
        sendPacket(16'h5600, 16'h0070, 16'h0000, 16'h000D);
        step();
        checkBit("mid access psel", apbReq.psel, 1'b1);
        #2;
        resetn = 1'b1;
        #1;
        checkBit("mid reset psel", apbReq.psel, 1'b0);
        checkBit("mid reset penable", apbReq.penable, 1'b0);
        checkBit("mid reset valid_out", validOut, 1'b0);
        checkBit("mid reset ready", ready, 1'b0);
        checkOutput("mid reset paddr", apbReq.paddr, 16'h0000);
        step();
        resetn = 1'b0;
        apbResp.pready = 1'b1;
        step();
        checkBit("post reset ready", ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checkBit($sformatf("post reset valid_out%0d", i), validOut, 1'b0);
            checkBit($sformatf("post reset psel%0d", i), apbReq.psel, 1'b0);
            step();
        end
        apbResp.prdata = 16'hA5A5;
        sendPacket(16'h5600, 16'h0060, 16'h0000, 16'h000C);
        checkOutput("post reset setup paddr", apbReq.paddr, 16'h0060);
        step();
        step();
        checkResponse(16'h6500, 16'h0060, 16'hA5A5, 16'h000C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
